// File: rtl/fsm_iter_pkg.sv
// fsm_iter shared types.
// State encoding and step-direction constants.
package fsm_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_INC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/fsm_iter_if.sv
// fsm_iter request/result bundle.
// master = producer/consumer side, slave = fsm_iter.
interface fsm_iter_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);

  logic              start;
  logic [DATA_W-1:0] in;
  logic [CNT_W-1:0]  iters;
  logic              mode;
  logic              ack;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out;
  logic              wrap;

  modport master (
    output start, in, iters, mode, ack,
    input  busy, done, out, wrap
  );

  modport slave (
    input  start, in, iters, mode, ack,
    output busy, done, out, wrap
  );

endinterface

// File: rtl/fsm_iter.sv
// Iterative +1/-1 stepper with capture/run/done handshake.
// Result held in DONE until ack; start+ack chains back-to-back.
module fsm_iter
  import fsm_iter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  fsm_iter_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic              accept;
  logic [DATA_W:0]   step_w;

  // One step with the carry/borrow landing in the top bit.
  always_comb begin
    step_w = '0;
    if (mode_q == MODE_DEC)
      step_w = {1'b0, data_q} - (DATA_W+1)'(1);
    else
      step_w = {1'b0, data_q} + (DATA_W+1)'(1);
  end

  // Next state and datapath loads.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start)
          accept = 1'b1;
      end
      RUN: begin
        data_d  = step_w[DATA_W-1:0];
        wrap_d  = wrap_q | step_w[DATA_W];
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        if (bus.ack) begin
          if (bus.start)
            accept = 1'b1;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      data_d  = bus.in;
      count_d = bus.iters;
      mode_d  = bus.mode;
      wrap_d  = 1'b0;
      state_d = (bus.iters != '0) ? RUN : DONE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.out  = (state_q == DONE) ? data_q : '0;
  assign bus.wrap = (state_q == DONE) ? wrap_q : 1'b0;

endmodule

// File: tb/tb_fsm_iter.sv
// Directed bench for fsm_iter.
// 8/4 instance for main cases, 16/8 instance for width sweep.
module tb_fsm_iter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  fsm_iter_if #(.DATA_W(8),  .CNT_W(4)) a_if();
  fsm_iter_if #(.DATA_W(16), .CNT_W(8)) b_if();

  fsm_iter #(.DATA_W(8), .CNT_W(4)) u_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  fsm_iter #(.DATA_W(16), .CNT_W(8)) u_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 8-bit unit and check latency and result.
  task automatic op8(input logic [7:0] din,
                     input logic [3:0] it,
                     input logic       md,
                     input int         lat,
                     input logic [7:0] exp_out,
                     input logic       exp_wrap);
    int n;
    a_if.start = 1'b1;
    a_if.in    = din;
    a_if.iters = it;
    a_if.mode  = md;
    step();
    a_if.start = 1'b0;
    a_if.in    = 8'h00;
    n = 0;
    while (!a_if.done && n < 40) begin
      chk("busy_run", 32'(a_if.busy), 32'd1);
      step();
      n++;
    end
    chk("lat", 32'(n), 32'(lat));
    chk("out", 32'(a_if.out), 32'(exp_out));
    chk("wrap", 32'(a_if.wrap), 32'(exp_wrap));
  endtask

  task automatic ack8();
    a_if.ack = 1'b1;
    step();
    a_if.ack = 1'b0;
    chk("ack_done", 32'(a_if.done), 32'd0);
    chk("ack_busy", 32'(a_if.busy), 32'd0);
  endtask

  initial begin
    int n;
    a_if.start = 1'b0;
    a_if.in    = '0;
    a_if.iters = '0;
    a_if.mode  = 1'b0;
    a_if.ack   = 1'b0;
    b_if.start = 1'b0;
    b_if.in    = '0;
    b_if.iters = '0;
    b_if.mode  = 1'b0;
    b_if.ack   = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_done", 32'(a_if.done), 32'd0);
    chk("rst_out",  32'(a_if.out),  32'd0);
    chk("rst_wrap", 32'(a_if.wrap), 32'd0);
    reset_n = 1'b1;
    step();

    // reset in the middle of RUN
    a_if.start = 1'b1;
    a_if.in    = 8'h10;
    a_if.iters = 4'd5;
    a_if.mode  = 1'b0;
    step();
    a_if.start = 1'b0;
    chk("mid_busy", 32'(a_if.busy), 32'd1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mrst_busy", 32'(a_if.busy), 32'd0);
    chk("mrst_done", 32'(a_if.done), 32'd0);
    chk("mrst_out",  32'(a_if.out),  32'd0);

    // increment, then hold without ack
    op8(8'h10, 4'd3, 1'b0, 3, 8'h13, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_done", 32'(a_if.done), 32'd1);
      chk("hold_out",  32'(a_if.out),  32'h13);
    end
    ack8();

    // zero iterations, start ignored without ack
    op8(8'hA5, 4'd0, 1'b0, 0, 8'hA5, 1'b0);
    a_if.start = 1'b1;
    a_if.in    = 8'h00;
    a_if.iters = 4'd2;
    step();
    a_if.start = 1'b0;
    chk("ign_done", 32'(a_if.done), 32'd1);
    chk("ign_out",  32'(a_if.out),  32'hA5);
    step();
    chk("ign_out2", 32'(a_if.out),  32'hA5);
    ack8();

    // wrap both ways
    op8(8'hFE, 4'd4, 1'b0, 4, 8'h02, 1'b1);
    ack8();
    op8(8'h01, 4'd2, 1'b1, 2, 8'hFF, 1'b1);

    // back-to-back accept from DONE
    a_if.ack   = 1'b1;
    a_if.start = 1'b1;
    a_if.in    = 8'h40;
    a_if.iters = 4'd1;
    a_if.mode  = 1'b0;
    step();
    a_if.ack   = 1'b0;
    a_if.start = 1'b0;
    chk("b2b_busy", 32'(a_if.busy), 32'd1);
    chk("b2b_done", 32'(a_if.done), 32'd0);
    chk("b2b_wrap", 32'(a_if.wrap), 32'd0);
    step();
    chk("b2b_done2", 32'(a_if.done), 32'd1);
    chk("b2b_out",   32'(a_if.out),  32'h41);
    chk("b2b_wrap2", 32'(a_if.wrap), 32'd0);
    ack8();

    // 16-bit width sweep
    b_if.start = 1'b1;
    b_if.in    = 16'hFFF0;
    b_if.iters = 8'd255;
    b_if.mode  = 1'b0;
    step();
    b_if.start = 1'b0;
    n = 0;
    while (!b_if.done && n < 400) begin
      step();
      n++;
    end
    chk("w16_lat",  32'(n),          32'd255);
    chk("w16_out",  32'(b_if.out),   32'h00EF);
    chk("w16_wrap", 32'(b_if.wrap),  32'd1);
    b_if.ack = 1'b1;
    step();
    b_if.ack = 1'b0;
    chk("w16_idle", 32'(b_if.busy),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
